// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache, the memory arbiter and the tagged memory port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      proc2Imem_command;
    logic [XLEN-1:0] proc2Imem_addr;
    logic [1:0]      proc2Dmem_command;
    logic [XLEN-1:0] proc2Dmem_addr;
    logic [63:0]     proc2Dmem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      Imem2proc_response;
    logic [63:0]     Imem2proc_data;
    logic [3:0]      Imem2proc_tag;
    logic [3:0]      Dmem2proc_response;
    logic [63:0]     Dmem2proc_data;
    logic [3:0]      Dmem2proc_tag;
    logic            grant_d;

    modport slave (
        input  proc2Imem_command, proc2Imem_addr,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output grant_d
    );

    modport master (
        output proc2Imem_command, proc2Imem_addr,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter for one tagged memory port, with a per-tag owner table for load returns.
// Define ARB_FAIR_EN to force the icache through after STARVE_LIMIT contested dcache wins.
module mem_arbiter #(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 8
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [4:0] TAG_LIMIT = 5'(NUM_TAGS);

    if (NUM_TAGS < 2 || NUM_TAGS > 16) begin : g_bad_num_tags
        $error("mem_arbiter: NUM_TAGS must be in 2..16");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    logic       d_req;
    logic       i_req;
    logic       grant_d_c;
    logic       grant_i_c;
    logic [1:0] gnt_cmd;

    assign d_req = (bus.proc2Dmem_command != BUS_NONE);
    assign i_req = (bus.proc2Imem_command == BUS_LOAD);

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             store_rej_q;
    logic             both_req;
    logic             force_i;

    // A store the memory just bounced keeps its turn; the forced icache slot waits a cycle.
    assign both_req = d_req && i_req;
    assign force_i  = both_req && (starve_cnt == LIMIT) &&
                      !(store_rej_q && (bus.proc2Dmem_command == BUS_STORE));
    assign grant_d_c = d_req && !force_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= '0;
            store_rej_q <= 1'b0;
        end else begin
            store_rej_q <= grant_d_c && (bus.proc2Dmem_command == BUS_STORE) &&
                           (bus.mem2proc_response == 4'd0);
            if (!both_req || force_i)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign grant_d_c = d_req;
`endif

    assign grant_i_c   = !grant_d_c && i_req;
    assign bus.grant_d = grant_d_c;

    always_comb begin
        gnt_cmd                = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Imem2proc_response = 4'd0;
        bus.Dmem2proc_response = 4'd0;
        if (grant_d_c) begin
            gnt_cmd                = bus.proc2Dmem_command;
            bus.proc2mem_addr      = bus.proc2Dmem_addr;
            bus.proc2mem_data      = bus.proc2Dmem_data;
            bus.Dmem2proc_response = bus.mem2proc_response;
        end else if (grant_i_c) begin
            gnt_cmd                = BUS_LOAD;
            bus.proc2mem_addr      = bus.proc2Imem_addr;
            bus.Imem2proc_response = bus.mem2proc_response;
        end
    end

    assign bus.proc2mem_command = gnt_cmd;
    assign bus.Imem2proc_data   = bus.mem2proc_data;
    assign bus.Dmem2proc_data   = bus.mem2proc_data;

    logic [NUM_TAGS-1:0] tag_valid;
    logic [NUM_TAGS-1:0] tag_owner_d;
    logic [3:0]          rtn_tag;
    logic [3:0]          alloc_tag;
    logic                tag_hit;
    logic                alloc;

    assign rtn_tag   = bus.mem2proc_tag;
    assign alloc_tag = bus.mem2proc_response;
    assign tag_hit   = (rtn_tag != 4'd0) && ({1'b0, rtn_tag} < TAG_LIMIT) && tag_valid[rtn_tag];
    assign alloc     = (gnt_cmd == BUS_LOAD) && (alloc_tag != 4'd0) &&
                       ({1'b0, alloc_tag} < TAG_LIMIT);

    always_comb begin
        bus.Imem2proc_tag = 4'd0;
        bus.Dmem2proc_tag = 4'd0;
        if (tag_hit) begin
            if (tag_owner_d[rtn_tag])
                bus.Dmem2proc_tag = rtn_tag;
            else
                bus.Imem2proc_tag = rtn_tag;
        end
    end

    // Owner table: release first so a same-cycle allocation of that tag takes precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
        end else begin
            if (tag_hit)
                tag_valid[rtn_tag] <= 1'b0;
            if (alloc)
                tag_valid[alloc_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (alloc)
            tag_owner_d[alloc_tag] <= grant_d_c;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a tag-ownership reference model.
module tb_mem_arbiter;
    localparam int XLEN         = 32;
    localparam int NUM_TAGS     = 16;
    localparam int STARVE_LIMIT = 8;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(.NUM_TAGS(NUM_TAGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int owner [NUM_TAGS];   // 0 = free, 1 = icache, 2 = dcache
    int m_cnt;
    bit m_prev_rej;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ic, input logic [31:0] ia,
                         input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                         input logic [3:0] r, input logic [63:0] md, input logic [3:0] t);
        bus.proc2Imem_command = ic;
        bus.proc2Imem_addr    = ia;
        bus.proc2Dmem_command = dc;
        bus.proc2Dmem_addr    = da;
        bus.proc2Dmem_data    = dd;
        bus.mem2proc_response = r;
        bus.mem2proc_data     = md;
        bus.mem2proc_tag      = t;
    endtask

    task automatic idle(input logic [3:0] t);
        drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h0, t);
    endtask

    // Checks the settled outputs of the current cycle against the model, then books the edge.
    task automatic step();
        logic [1:0]  ic, dc, ecmd;
        logic [31:0] eaddr;
        logic [63:0] edata;
        logic [3:0]  r, t, eir, edr, eit, edt;
        bit both, frc, gd, gi;
        #4;
        ic = bus.proc2Imem_command;
        dc = bus.proc2Dmem_command;
        r  = bus.mem2proc_response;
        t  = bus.mem2proc_tag;
        both = (ic == BUS_LOAD) && (dc != BUS_NONE);
        frc  = 1'b0;
`ifdef ARB_FAIR_EN
        frc = both && (m_cnt == STARVE_LIMIT) && !(m_prev_rej && dc == BUS_STORE);
`endif
        gd    = (dc != BUS_NONE) && !frc;
        gi    = !gd && (ic == BUS_LOAD);
        ecmd  = gd ? dc : (gi ? BUS_LOAD : BUS_NONE);
        eaddr = gd ? bus.proc2Dmem_addr : (gi ? bus.proc2Imem_addr : 32'h0);
        edata = gd ? bus.proc2Dmem_data : 64'h0;
        eir   = gi ? r : 4'd0;
        edr   = gd ? r : 4'd0;
        eit   = (t != 0 && owner[t] == 1) ? t : 4'd0;
        edt   = (t != 0 && owner[t] == 2) ? t : 4'd0;
        chk("cmd",     bus.proc2mem_command,   ecmd);
        chk("addr",    bus.proc2mem_addr,      eaddr);
        chk("wdata",   bus.proc2mem_data,      edata);
        chk("i_resp",  bus.Imem2proc_response, eir);
        chk("d_resp",  bus.Dmem2proc_response, edr);
        chk("i_tag",   bus.Imem2proc_tag,      eit);
        chk("d_tag",   bus.Dmem2proc_tag,      edt);
        chk("grant_d", bus.grant_d,            gd);
        chk("i_data",  bus.Imem2proc_data,     bus.mem2proc_data);
        chk("d_data",  bus.Dmem2proc_data,     bus.mem2proc_data);
        if (reset) begin
            foreach (owner[k]) owner[k] = 0;
            m_cnt      = 0;
            m_prev_rej = 1'b0;
        end else begin
            if (t != 0) owner[t] = 0;
            if (ecmd == BUS_LOAD && r != 0) owner[r] = gd ? 2 : 1;
            if (!both || gi) m_cnt = 0;
            else if (m_cnt < STARVE_LIMIT) m_cnt++;
            m_prev_rej = gd && (dc == BUS_STORE) && (r == 0);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int free_list[$];
        logic [1:0] ic, dc;
        logic [3:0] r, t;

        foreach (owner[k]) owner[k] = 0;
        m_cnt      = 0;
        m_prev_rej = 1'b0;
        reset = 1'b1;
        idle(4'd0);
        adv();
        step(); adv();
        step(); adv();
        reset = 1'b0;

        // Reset state with no requests
        idle(4'd0); step();
        chk("rst_cmd",  bus.proc2mem_command, BUS_NONE);
        chk("rst_itag", bus.Imem2proc_tag, 4'd0);
        adv();

        // Icache load, response 3, data tag 3 five cycles later
        drive(BUS_LOAD, 32'h100, BUS_NONE, 32'h0, 64'h0, 4'd3, 64'h0, 4'd0); step();
        chk("tp1_iresp", bus.Imem2proc_response, 4'd3);
        chk("tp1_dresp", bus.Dmem2proc_response, 4'd0);
        chk("tp1_addr",  bus.proc2mem_addr, 32'h100);
        adv();
        for (int i = 0; i < 4; i++) begin idle(4'd0); step(); adv(); end
        drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h1234_5678_9abc_def0, 4'd3); step();
        chk("tp1_itag", bus.Imem2proc_tag, 4'd3);
        chk("tp1_dtag", bus.Dmem2proc_tag, 4'd0);
        chk("tp1_idata", bus.Imem2proc_data, 64'h1234_5678_9abc_def0);
        adv();
        idle(4'd3); step();
        chk("tp1_clr", {bus.Imem2proc_tag, bus.Dmem2proc_tag}, 8'h00);
        adv();

        // Simultaneous requests: dcache priority
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h1008, 64'h0, 4'd5, 64'h0, 4'd0); step();
        chk("tp2_addr",  bus.proc2mem_addr, 32'h1008);
        chk("tp2_dresp", bus.Dmem2proc_response, 4'd5);
        chk("tp2_iresp", bus.Imem2proc_response, 4'd0);
        adv();
        idle(4'd5); step();
        chk("tp2_dtag", bus.Dmem2proc_tag, 4'd5);
        chk("tp2_itag", bus.Imem2proc_tag, 4'd0);
        adv();

        // Store never allocates
        drive(BUS_NONE, 32'h0, BUS_STORE, 32'h2000, 64'hDEADBEEF_00000001, 4'd7, 64'h0, 4'd0); step();
        chk("tp3_cmd",   bus.proc2mem_command, BUS_STORE);
        chk("tp3_data",  bus.proc2mem_data, 64'hDEADBEEF_00000001);
        chk("tp3_dresp", bus.Dmem2proc_response, 4'd7);
        adv();
        idle(4'd7); step();
        chk("tp3_stray", {bus.Imem2proc_tag, bus.Dmem2proc_tag}, 8'h00);
        adv();

        // Same-cycle release (icache) and allocation (dcache) of tag 4
        drive(BUS_LOAD, 32'h300, BUS_NONE, 32'h0, 64'h0, 4'd4, 64'h0, 4'd0); step(); adv();
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'h3000, 64'h0, 4'd4, 64'h0, 4'd4); step();
        chk("tp4_itag", bus.Imem2proc_tag, 4'd4);
        chk("tp4_dtag", bus.Dmem2proc_tag, 4'd0);
        adv();
        idle(4'd4); step();
        chk("tp4_dtag2", bus.Dmem2proc_tag, 4'd4);
        chk("tp4_itag2", bus.Imem2proc_tag, 4'd0);
        adv();

        // Reset abandons outstanding tags 2 and 9
        drive(BUS_LOAD, 32'h400, BUS_NONE, 32'h0, 64'h0, 4'd2, 64'h0, 4'd0); step(); adv();
        drive(BUS_NONE, 32'h0, BUS_LOAD, 32'h4000, 64'h0, 4'd9, 64'h0, 4'd0); step(); adv();
        reset = 1'b1;
        idle(4'd0); step(); adv();
        reset = 1'b0;
        idle(4'd2); step();
        chk("tp5_tag2", {bus.Imem2proc_tag, bus.Dmem2proc_tag}, 8'h00);
        adv();
        idle(4'd9); step();
        chk("tp5_tag9", {bus.Imem2proc_tag, bus.Dmem2proc_tag}, 8'h00);
        adv();

        // Continuous contention
        for (int k = 0; k < 2 * (STARVE_LIMIT + 1); k++) begin
            drive(BUS_LOAD, 32'h500, BUS_LOAD, 32'h5000, 64'h0, 4'd0, 64'h0, 4'd0); step();
`ifdef ARB_FAIR_EN
            chk("fair_grant", bus.grant_d, (k % (STARVE_LIMIT + 1)) != STARVE_LIMIT);
`else
            chk("prio_grant", bus.grant_d, 1'b1);
`endif
            adv();
        end

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            ic = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
            case ($urandom_range(0, 3))
                0:       dc = BUS_NONE;
                1:       dc = BUS_STORE;
                default: dc = BUS_LOAD;
            endcase
            free_list.delete();
            for (int k = 1; k < NUM_TAGS; k++) if (owner[k] == 0) free_list.push_back(k);
            r = 4'd0;
            if (free_list.size() > 0 && $urandom_range(0, 9) < 6)
                r = 4'(free_list[$urandom_range(0, free_list.size() - 1)]);
            t = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, NUM_TAGS - 1)) : 4'd0;
            drive(ic, $urandom & 32'hFFFF_FFF8, dc, $urandom, {$urandom, $urandom},
                  r, {$urandom, $urandom}, t);
            step();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
